// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad entry path.
//   state_e       : entry FSM state encoding
//   KEY_STAR/HASH : raw key codes {row, col} of the backspace and clear keys
//   REPEAT_*      : auto-repeat intervals in 1 ms ticks (first repeat, then period)
//   key_digit()   : raw key code -> {is_digit, bcd}
//   row_decode()  : active-low row pattern -> {valid, row_idx}; two or more low rows are invalid
package keypad_pkg;

  typedef enum logic [2:0] {
    StScan,
    StDebounce,
    StAccept,
    StHold,
    StRelease
  } state_e;

  localparam logic [3:0] KEY_STAR     = 4'hC;
  localparam logic [3:0] KEY_HASH     = 4'hE;
  localparam logic [8:0] REPEAT_FIRST = 9'd500;
  localparam logic [8:0] REPEAT_NEXT  = 9'd100;

  // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic logic [4:0] key_digit(input logic [3:0] code);
    logic [4:0] res;
    res = 5'h00;
    case (code)
      4'h0: res = {1'b1, 4'd1};
      4'h1: res = {1'b1, 4'd2};
      4'h2: res = {1'b1, 4'd3};
      4'h4: res = {1'b1, 4'd4};
      4'h5: res = {1'b1, 4'd5};
      4'h6: res = {1'b1, 4'd6};
      4'h8: res = {1'b1, 4'd7};
      4'h9: res = {1'b1, 4'd8};
      4'hA: res = {1'b1, 4'd9};
      4'hD: res = {1'b1, 4'd0};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] row_decode(input logic [3:0] rows);
    logic [2:0] res;
    res = 3'b000;
    unique case (rows)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms time base: free-running counter 0..T1MS, tick high while the counter sits at T1MS.
//   CLK  : system clock
//   RST  : synchronous active-high reset
//   tick : one-cycle strobe per period
module ms_tick_gen #(
  parameter logic [15:0] T1MS = 16'd49999
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  logic [15:0] c1_q, c1_d;

  assign tick = (c1_q == T1MS);

  always_comb begin
    c1_d = tick ? 16'd0 : c1_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      c1_q <= 16'd0;
    end else begin
      c1_q <= c1_d;
    end
  end

endmodule

// File: rtl/keypad_entry_module.sv
// 4x4 active-low matrix keypad scanner with debounce, assembling a 6-digit BCD number.
//   CLK        : system clock
//   RST        : synchronous active-high reset
//   Row_Sig    : keypad rows, pulled up, low = key closed on the driven column
//   Col_Data   : column drive, one-hot-low
//   Number_Sig : assembled BCD value, [23:20] most significant digit
//   Key_Code   : {row_idx, col_idx} of the last accepted key
//   Key_Valid  : one-cycle pulse per accepted key
// Optional feature: define KEY_REPEAT_EN for auto-repeat of digit and '*' keys while held.
module keypad_entry_module
  import keypad_pkg::*;
#(
  parameter logic [15:0] T1MS        = 16'd49999,
  parameter logic [4:0]  DEBOUNCE_MS = 5'd20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  Row_Sig,
  output logic [3:0]  Col_Data,
  output logic [23:0] Number_Sig,
  output logic [3:0]  Key_Code,
  output logic        Key_Valid
);

  logic        tick;
  logic [3:0]  row_meta_q, row_sync_q;
  state_e      state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  row_lat_q, row_lat_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  col_data_q, col_data_d;
  logic [23:0] number_q, number_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic [2:0]  row_dec;
  logic [4:0]  digit;
  logic        all_high;
`ifdef KEY_REPEAT_EN
  logic [8:0]  rpt_cnt_q, rpt_cnt_d, rpt_next;
  logic        rpt_first_q, rpt_first_d;
  logic [4:0]  held_digit;
  logic        repeatable;
`endif

  ms_tick_gen #(
    .T1MS(T1MS)
  ) u_ms_tick_gen (
    .CLK (CLK),
    .RST (RST),
    .tick(tick)
  );

  assign row_dec  = row_decode(row_sync_q);
  assign all_high = (row_sync_q == 4'hF);

  // Rows are asynchronous to CLK; resynchronise before sampling.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= Row_Sig;
      row_sync_q <= row_meta_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StScan;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      row_lat_q   <= 4'hF;
      cnt_q       <= 5'd0;
      col_data_q  <= 4'b1110;
      number_q    <= 24'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt_q   <= 9'd0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      row_lat_q   <= row_lat_d;
      cnt_q       <= cnt_d;
      col_data_q  <= col_data_d;
      number_q    <= number_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEY_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    row_lat_d = row_lat_q;
    cnt_d     = cnt_q;
`ifdef KEY_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_next    = rpt_cnt_q + 9'd1;
    held_digit  = key_digit(key_code_q);
    repeatable  = held_digit[4] || (key_code_q == KEY_STAR);
`endif
    unique case (state_q)
      StScan: begin
        if (tick) begin
          if (row_dec[2]) begin
            state_d   = StDebounce;
            row_lat_d = row_sync_q;
            row_idx_d = row_dec[1:0];
            cnt_d     = 5'd1;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      StDebounce: begin
        if (tick) begin
          if (row_sync_q != row_lat_q) begin
            state_d   = StScan;
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = 5'd0;
          end else if (cnt_q >= DEBOUNCE_MS) begin
            // Accept lands DEBOUNCE_MS ticks after the first valid sample.
            state_d = StAccept;
            cnt_d   = 5'd0;
`ifdef KEY_REPEAT_EN
            rpt_first_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StAccept: begin
        state_d = StHold;
`ifdef KEY_REPEAT_EN
        rpt_cnt_d = 9'd0;
`endif
      end
      StHold: begin
        if (tick) begin
          if (all_high) begin
            state_d = StRelease;
            cnt_d   = 5'd1;
          end
`ifdef KEY_REPEAT_EN
          else begin
            rpt_cnt_d = rpt_next;
            if (repeatable && (rpt_next == (rpt_first_q ? REPEAT_FIRST : REPEAT_NEXT))) begin
              state_d     = StAccept;
              rpt_first_d = 1'b0;
            end
          end
`endif
        end
      end
      StRelease: begin
        if (tick) begin
          if (!all_high) begin
            state_d = StHold;
            cnt_d   = 5'd0;
          end else if (cnt_q >= DEBOUNCE_MS) begin
            state_d   = StScan;
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Output registers load from next-state so Key_Valid, Key_Code and Number_Sig move together.
  always_comb begin
    col_data_d  = ~(4'b0001 << col_idx_d);
    key_valid_d = (state_d == StAccept);
    key_code_d  = key_code_q;
    number_d    = number_q;
    digit       = key_digit({row_idx_d, col_idx_d});
    if (key_valid_d) begin
      key_code_d = {row_idx_d, col_idx_d};
      if (digit[4]) begin
        number_d = {number_q[19:0], digit[3:0]};
      end else if (key_code_d == KEY_STAR) begin
        number_d = {4'h0, number_q[23:4]};
      end else if (key_code_d == KEY_HASH) begin
        number_d = 24'h0;
      end
    end
  end

  assign Col_Data   = col_data_q;
  assign Number_Sig = number_q;
  assign Key_Code   = key_code_q;
  assign Key_Valid  = key_valid_q;

endmodule

// File: tb/tb_keypad_entry_module.sv
module tb_keypad_entry_module;

  localparam int TB_T1MS = 9;
  localparam int DEB     = 3;

  typedef struct {
    logic [3:0]  code;
    logic [23:0] num;
  } exp_t;

  logic        clk, rst;
  logic [3:0]  row_sig, col_data, key_code;
  logic [23:0] number_sig;
  logic        key_valid;

  logic        key_on, ghost_on;
  logic [1:0]  key_row, key_col, ghost_row;

  int          checks, errors, kv_count, kv_tick;
  int          tb_c1   = 0;
  int          tick_no = 0;
  logic [23:0] model_num, last_num;
  exp_t        sb[$];
  int          kmap[16];
  logic [3:0]  rot[4];

  keypad_entry_module #(
    .T1MS       (16'd9),
    .DEBOUNCE_MS(5'd3)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .Row_Sig   (row_sig),
    .Col_Data  (col_data),
    .Number_Sig(number_sig),
    .Key_Code  (key_code),
    .Key_Valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a closed key pulls its row low only while its column is driven.
  always_comb begin
    row_sig = 4'hF;
    if (key_on && col_data[key_col] == 1'b0) row_sig[key_row] = 1'b0;
    if (ghost_on && col_data[key_col] == 1'b0) row_sig[ghost_row] = 1'b0;
  end

  // Reference 1 ms time base.
  always @(posedge clk) begin
    if (rst) begin
      tb_c1 <= 0;
    end else if (tb_c1 == TB_T1MS) begin
      tb_c1   <= 0;
      tick_no <= tick_no + 1;
    end else begin
      tb_c1 <= tb_c1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_pre_tick();
    @(negedge clk);
    while (tb_c1 != TB_T1MS) @(negedge clk);
  endtask

  task automatic wait_tick();
    wait_pre_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input int r, input int c);
    exp_t e;
    int   k;
    k = kmap[r*4+c];
    if (k <= 9) model_num = {model_num[19:0], 4'(k)};
    else if (k == 14) model_num = {4'h0, model_num[23:4]};
    else if (k == 15) model_num = 24'h0;
    e.code = 4'(r*4+c);
    e.num  = model_num;
    sb.push_back(e);
  endtask

  task automatic press(input int r, input int c, input int hold_ticks, input int reps);
    int base, n;
    base = kv_count;
    for (int i = 0; i < reps; i++) push_key(r, c);
    key_row = 2'(r);
    key_col = 2'(c);
    key_on  = 1'b1;
    n = 0;
    while (kv_count == base && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    repeat (hold_ticks) wait_tick();
    key_on = 1'b0;
    repeat (DEB + 3) wait_tick();
    chk("pulses", kv_count - base, reps);
  endtask

  // Scoreboard monitor: pops one expectation per Key_Valid, checks Number_Sig stable otherwise.
  initial begin
    kv_count = 0;
    kv_tick  = -1;
    last_num = 24'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_num = 24'h0;
      end else if (key_valid) begin
        kv_count++;
        kv_tick = tick_no;
        chk("kv_phase", tb_c1, 0);
        if (sb.size() == 0) begin
          chk("kv_unexpected", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("kv_code", 32'(key_code), 32'(e.code));
          chk("kv_number", 32'(number_sig), 32'(e.num));
          last_num = e.num;
        end
      end else begin
        chk("num_stable", 32'(number_sig), 32'(last_num));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, stable, found;
    logic [3:0] c0;
    kmap = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    rot  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    checks = 0;
    errors = 0;
    model_num = 24'h0;
    key_on = 1'b0;
    ghost_on = 1'b0;
    key_row = 2'd0;
    key_col = 2'd0;
    ghost_row = 2'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values and column rotation
    chk("rst_col", 32'(col_data), 32'(4'b1110));
    chk("rst_num", 32'(number_sig), 32'(24'h0));
    chk("rst_code", 32'(key_code), 32'(4'h0));
    chk("rst_valid", 32'(key_valid), 32'(1'b0));
    wait_pre_tick();
    chk("col_hold", 32'(col_data), 32'(4'b1110));
    @(posedge clk);
    #1;
    chk("rot0", 32'(col_data), 32'(rot[0]));
    for (int i = 1; i < 4; i++) begin
      wait_tick();
      chk("rot", 32'(col_data), 32'(rot[i]));
    end

    // Digit entry 1, 2, 3
    press(0, 0, 1, 1);
    press(0, 1, 1, 1);
    press(0, 2, 1, 1);
    chk("num_123", 32'(number_sig), 32'(24'h000123));

    // Ghost: two rows low on column 0 must be ignored, scan keeps rotating
    key_row = 2'd0; key_col = 2'd0; ghost_row = 2'd2;
    key_on = 1'b1; ghost_on = 1'b1;
    base = kv_count;
    repeat (12) wait_tick();
    chk("ghost_none", kv_count, base);
    c0 = col_data;
    wait_tick();
    chk("ghost_scan", 32'(col_data), 32'({c0[2:0], c0[3]}));
    key_on = 1'b0; ghost_on = 1'b0;
    repeat (2) wait_tick();

    // Reset in the middle of debounce of key 9
    key_row = 2'd2; key_col = 2'd2; key_on = 1'b1;
    base = kv_count;
    found = 0; n = 0;
    while (found == 0 && n < 12) begin
      wait_pre_tick();
      if (col_data[2] == 1'b0) found = 1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_dbg_seen", found, 1);
    wait_tick();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    key_on = 1'b0;
    model_num = 24'h0;
    chk("rst2_col", 32'(col_data), 32'(4'b1110));
    chk("rst2_num", 32'(number_sig), 32'(24'h0));
    chk("rst2_code", 32'(key_code), 32'(4'h0));
    chk("rst2_valid", 32'(key_valid), 32'(1'b0));
    repeat (10) wait_tick();
    chk("rst2_none", kv_count, base);

    // Overflow, letter, backspace, clear
    press(0, 0, 1, 1);
    press(0, 1, 1, 1);
    press(0, 2, 1, 1);
    press(1, 0, 1, 1);
    press(1, 1, 1, 1);
    press(1, 2, 1, 1);
    press(2, 0, 1, 1);
    chk("num_ovf", 32'(number_sig), 32'(24'h234567));
    press(0, 3, 1, 1);
    chk("num_letter", 32'(number_sig), 32'(24'h234567));
    chk("code_letter", 32'(key_code), 32'(4'h3));
    press(3, 0, 1, 1);
    chk("num_star", 32'(number_sig), 32'(24'h023456));
    press(3, 2, 1, 1);
    chk("num_hash", 32'(number_sig), 32'(24'h000000));

    // Bounce on key 5, then stable press
    key_row = 2'd1; key_col = 2'd1;
    base = kv_count;
    for (int i = 0; i < 6; i++) begin
      key_on = (i % 2 == 0);
      wait_tick();
    end
    push_key(1, 1);
    key_on = 1'b1;
    stable = -1; n = 0;
    while (kv_count == base && n < 20) begin
      wait_pre_tick();
      if (stable < 0 && col_data[1] == 1'b0) stable = tick_no + 1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("bounce_lat", kv_tick, stable + DEB);
    key_on = 1'b0;
    repeat (DEB + 3) wait_tick();
    chk("bounce_pulses", kv_count - base, 1);
    chk("num_bounce", 32'(number_sig), 32'(24'h000005));

    // Long hold of 5 from a cleared value
    press(3, 2, 1, 1);
`ifdef KEY_REPEAT_EN
    press(1, 1, 805, 5);
    chk("num_hold", 32'(number_sig), 32'(24'h055555));
`else
    press(1, 1, 805, 1);
    chk("num_hold", 32'(number_sig), 32'(24'h000005));
`endif
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_module.md
# keypad_entry_module

Matrix-keypad entry block for the 6-digit display path: scans a 4x4 active-low keypad, debounces presses, and assembles a 6-digit BCD number on `Number_Sig[23:0]`. `Number_Sig` has the same format the digit-multiplexing display control consumes (bits [23:20] hundred-thousands … [3:0] units). It is the input-side counterpart of the display scan. It shares the 1 ms scan base and time-slot scheme, but reads rows instead of driving digits.

## Interface
- `T1MS`, default 16'd49999: terminal count of the 1 ms tick counter (50 MHz CLK).
- `DEBOUNCE_MS`, default 5'd20: consecutive stable 1 ms samples required to accept a press or a release.
- `CLK`, input, 1 bit: system clock.
- `RST`, input, 1 bit: one clock; reset is synchronous and active-high.
- `Row_Sig`, input, 4 bits: keypad rows, externally pulled up, low = key closed on the driven column.
- `Col_Data`, output, 4 bits: column drive, exactly one bit low (one-hot-low), the others high.
- `Number_Sig`, output, 24 bits: assembled 6-digit BCD value.
- `Key_Code`, output, 4 bits: raw code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `Key_Valid`, output, 1 bit: one-cycle pulse per accepted key.

## Operation
- **Tick counter `C1`**
  - Counts 0..T1MS and wraps.
  - `tick` = (C1 == T1MS).
- **Key map (row, col)**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- **Key actions on acceptance**
  - Digit d: `Number_Sig <= {Number_Sig[19:0], d}`. The top digit is discarded on overflow.
  - `*` (backspace): `Number_Sig <= {4'h0, Number_Sig[23:4]}`.
  - `#` (clear): `Number_Sig <= 0`.
  - A–D: `Number_Sig` unchanged. `Key_Valid` and `Key_Code` still update.
- **Row sample**
  - Rows are sampled only on `tick`, at the end of a column slot, after settling.
  - Valid pattern: exactly one row low.
  - All-high: no key.
  - Two or more rows low: invalid, treated as no key (ghost rejection).
- **FSM states**
  - **SCAN**
    - On `tick`: if the pattern is valid, latch row/col and go to DEBOUNCE with count = 1.
    - Otherwise advance `col_idx` (3 wraps to 0).
  - **DEBOUNCE**
    - Column held.
    - On `tick`: if the pattern equals the latched pattern, increment count.
    - Otherwise return to SCAN and advance the column.
    - When count reaches DEBOUNCE_MS, go to ACCEPT.
  - **ACCEPT** (one cycle)
    - `Key_Valid` = 1, `Key_Code` and `Number_Sig` updated.
    - Next state HOLD.
  - **HOLD**
    - Column held.
    - On `tick` with all rows high, go to RELEASE with count = 1.
  - **RELEASE**
    - On `tick`: if all rows are high, increment count; any low row returns to HOLD.
    - At DEBOUNCE_MS, go to SCAN and advance the column.
- Only one key is tracked at a time. Other keys pressed during HOLD/RELEASE on other columns are not seen.

## Timing
- Reset values:
  - `Col_Data` = 4'b1110
  - `Number_Sig` = 0
  - `Key_Code` = 0
  - `Key_Valid` = 0
  - FSM = SCAN, `col_idx` = 0, `C1` = 0, debounce count = 0
- `RST` asserted mid-debounce or mid-hold aborts the operation; nothing is accepted.
- `Col_Data` changes only on the cycle after a `tick` that advances the column.
- Press-to-`Key_Valid` latency: DEBOUNCE_MS ticks after the first valid sample, plus 1 CLK.
- `Number_Sig` and `Key_Code` change in the same cycle `Key_Valid` is high and are stable at all other times.
- Minimum gap between two `Key_Valid` pulses: 2×DEBOUNCE_MS ms.
- All outputs are registered.

## Configuration
- **`KEY_REPEAT_EN` defined:** auto-repeat is enabled.
  - In HOLD, after 500 ticks held, the FSM re-enters ACCEPT.
  - Afterwards it re-enters ACCEPT every 100 ticks while the key stays held.
  - Repeat applies to digit keys and `*` only.
- **`KEY_REPEAT_EN` undefined:** exactly one `Key_Valid` per press, and no repeat counter is synthesized.

## Structure
- Shared package `keypad_pkg`:
  - FSM state encoding (SCAN, DEBOUNCE, ACCEPT, HOLD, RELEASE)
  - key-code constants `KEY_STAR` = 4'hC, `KEY_HASH` = 4'hE
  - the code-to-BCD lookup function
  - repeat constants 500/100
- One sub-module, `ms_tick_gen`: the parameterised T1MS counter producing `tick`. It is reused by the display control.

## Test plan
(Use T1MS = 9 and DEBOUNCE_MS = 3 in simulation.)
- **Reset:** `RST` high 2 cycles → `Col_Data` = 1110, `Number_Sig` = 0, `Key_Valid` = 0. Column rotates 1101, 1011, 0111, 1110 at every tick.
- **Digit entry:** press keys 1, 2, 3 in turn (row pulled low while the matching column is driven, held at least 3 ticks, then released) → one `Key_Valid` each, `Number_Sig` = 24'h000123.
- **Overflow, backspace, clear:** enter 1234567 → `Number_Sig` = 24'h234567. Then `*` → 24'h023456. Then `#` → 24'h000000.
- **Bounce:** row toggles low/high on alternating ticks for 6 ticks, then stable low → exactly one `Key_Valid`, 3 ticks after stabilising plus 1 CLK.
- **Ghost and reset:** two rows low simultaneously → no `Key_Valid`, scan continues. `RST` pulsed during DEBOUNCE → no acceptance, reset values restored.
- **Repeat (KEY_REPEAT_EN):** hold 5 for 800 ticks → `Key_Valid` at acceptance, at +500, and at +600/+700/+800 ticks. `Number_Sig` ends as 24'h055555. Without the macro → a single pulse and 24'h000005.
